// File: rtl/tog_event_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tog_event_rx
//  Purpose  : Receive side of a toggle-encoded event link. Synchronises the
//             asynchronous TOG wire, turns every level change into one event
//             pulse, queues events behind a valid/ack handshake, counts them
//             and flags queue overruns.
//  Options  : define TOG_RX_GLITCH_FILT_EN to require each new TOG level to
//             be stable for two consecutive cycles before it counts (rejects
//             single-cycle glitches, adds one cycle of latency and one PRIME
//             cycle).
//  Revision : 1.0  initial release
// ============================================================================
module tog_event_rx #(
  parameter int SYNC_STAGES = 2,  // legal range 2..4
  parameter int PEND_W      = 4,  // queue depth is 2^PEND_W-1
  parameter int CNT_W       = 8   // running event count, wraps
) (
  input  logic              CLK,
  input  logic              RST,        // asynchronous, active-low
  input  logic              TOG,
  input  logic              EN,
  input  logic              EVT_ACK,
  input  logic              CLR_OVR,
  output logic              EVT_PULSE,
  output logic              EVT_VALID,
  output logic [PEND_W-1:0] PEND_CNT,
  output logic [CNT_W-1:0]  EVT_CNT,
  output logic              OVR
);

  // PRIME masks detection until the synchroniser holds a real TOG sample,
  // so a line already high at reset release is not mistaken for an event.
`ifdef TOG_RX_GLITCH_FILT_EN
  localparam int PRIME_LEN = SYNC_STAGES + 2;
`else
  localparam int PRIME_LEN = SYNC_STAGES + 1;
`endif
  localparam logic [2:0]        PRIME_LAST = 3'(PRIME_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX   = '1;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
`ifdef TOG_RX_GLITCH_FILT_EN
  // Previous synchronised level, used to confirm a level is stable.
  logic                   hold_q, hold_d;
`endif
  state_t                 state_q, state_d;
  logic [2:0]             prime_cnt_q, prime_cnt_d;
  logic                   pulse_q, pulse_d;
  logic [PEND_W-1:0]      pend_q, pend_d;
  logic [CNT_W-1:0]       evt_cnt_q, evt_cnt_d;
  logic                   ovr_q, ovr_d;

  logic                   det;
  logic                   accept;
  logic                   ack_ok;
  logic                   valid;

  // Synchroniser shift and change detection on the synchronised level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], TOG};
`ifdef TOG_RX_GLITCH_FILT_EN
    hold_d = sync_q[SYNC_STAGES-1];
    prev_d = (sync_q[SYNC_STAGES-1] == hold_q) ? sync_q[SYNC_STAGES-1] : prev_q;
`else
    prev_d = sync_q[SYNC_STAGES-1];
`endif
    // prev only moves when a (filtered) level change is seen, so a change
    // of prev is exactly one detected event.
    det = prev_d ^ prev_q;
  end

  assign valid  = (pend_q != '0);
  assign accept = det & EN & (state_q != ST_PRIME);
  assign ack_ok = EVT_ACK & valid;

  // Pending queue depth, running count, overrun flag and event pulse.
  always_comb begin
    pend_d    = pend_q;
    evt_cnt_d = evt_cnt_q + {{(CNT_W-1){1'b0}}, accept};
    ovr_d     = ovr_q & ~CLR_OVR;
    pulse_d   = accept;
    if (accept && !ack_ok) begin
      if (pend_q == PEND_MAX) begin
        ovr_d = 1'b1;            // setting beats a same-cycle clear
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (!accept && ack_ok) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  // Next-state logic: PRIME timer, then IDLE/PEND track queue occupancy.
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    case (state_q)
      ST_PRIME: begin
        if (prime_cnt_q == PRIME_LAST) begin
          state_d = ST_IDLE;
        end else begin
          prime_cnt_d = prime_cnt_q + 3'd1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (pend_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_PRIME;
      end
    endcase
  end

  // All state registers; reset acts immediately and discards pending events.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
`ifdef TOG_RX_GLITCH_FILT_EN
      hold_q      <= 1'b0;
`endif
      state_q     <= ST_PRIME;
      prime_cnt_q <= 3'd0;
      pulse_q     <= 1'b0;
      pend_q      <= '0;
      evt_cnt_q   <= '0;
      ovr_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
`ifdef TOG_RX_GLITCH_FILT_EN
      hold_q      <= hold_d;
`endif
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      pulse_q     <= pulse_d;
      pend_q      <= pend_d;
      evt_cnt_q   <= evt_cnt_d;
      ovr_q       <= ovr_d;
    end
  end

  assign EVT_PULSE = pulse_q;
  assign EVT_VALID = valid;
  assign PEND_CNT  = pend_q;
  assign EVT_CNT   = evt_cnt_q;
  assign OVR       = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_tog_event_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_tog_event_rx
//  Purpose  : Self-checking bench for tog_event_rx. A reference model derives
//             each expected event from the TOG samples it sees; expected
//             pulses go into a scoreboard queue that a monitor drains.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tog_event_rx;

  localparam int SYNC_STAGES = 2;
  localparam int PEND_W      = 4;
  localparam int CNT_W       = 8;
`ifdef TOG_RX_GLITCH_FILT_EN
  localparam bit FILT      = 1'b1;
  localparam int PRIME_LEN = SYNC_STAGES + 2;
`else
  localparam bit FILT      = 1'b0;
  localparam int PRIME_LEN = SYNC_STAGES + 1;
`endif
  // Edges from the first sample of a new TOG level to the pulse edge.
  localparam int LAT      = SYNC_STAGES + (FILT ? 1 : 0);
  localparam int PEND_MAX = (1 << PEND_W) - 1;
  localparam int CNT_MOD  = 1 << CNT_W;

  logic              CLK = 1'b0;
  logic              RST;
  logic              TOG;
  logic              EN;
  logic              EVT_ACK;
  logic              CLR_OVR;
  logic              EVT_PULSE;
  logic              EVT_VALID;
  logic [PEND_W-1:0] PEND_CNT;
  logic [CNT_W-1:0]  EVT_CNT;
  logic              OVR;

  tog_event_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .PEND_W     (PEND_W),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .TOG      (TOG),
    .EN       (EN),
    .EVT_ACK  (EVT_ACK),
    .CLR_OVR  (CLR_OVR),
    .EVT_PULSE(EVT_PULSE),
    .EVT_VALID(EVT_VALID),
    .PEND_CNT (PEND_CNT),
    .EVT_CNT  (EVT_CNT),
    .OVR      (OVR)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int edge_n;
    int cnt;
    int pend;
    bit ovr;
  } exp_t;

  exp_t sb[$];        // expected pulses, oldest first
  int   chg_q[$];     // edge numbers at which a seen TOG change is decided
  int   m_edge  = 0;  // edges since reset release
  bit   m_samp  = 0;  // TOG sample at the previous edge
  bit   m_level = 0;  // confirmed level (filtered build)
  int   m_pend  = 0;
  int   m_cnt   = 0;
  bit   m_ovr   = 0;
  bit   m_acc, m_ack, m_set;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_edge = 0; m_samp = 0; m_level = 0;
      m_pend = 0; m_cnt = 0; m_ovr = 0;
      chg_q.delete();
      sb.delete();
    end else begin
      m_edge = m_edge + 1;
      m_acc  = 0;
      if (chg_q.size() > 0 && chg_q[0] == m_edge) begin
        void'(chg_q.pop_front());
        m_acc = EN && (m_edge > PRIME_LEN);
      end
      m_ack = EVT_ACK && (m_pend != 0);
      m_set = m_acc && !m_ack && (m_pend == PEND_MAX);
      if (m_acc) m_cnt = (m_cnt + 1) % CNT_MOD;
      if (m_acc && !m_ack && !m_set) m_pend = m_pend + 1;
      else if (!m_acc && m_ack)      m_pend = m_pend - 1;
      if (m_set)        m_ovr = 1;
      else if (CLR_OVR) m_ovr = 0;
      if (m_acc) sb.push_back('{m_edge, m_cnt, m_pend, m_ovr});
      // Classify this edge's TOG sample.
      if (!FILT) begin
        if (TOG != m_samp) chg_q.push_back(m_edge + LAT);
      end else begin
        // New level counts once seen on two consecutive samples; its first
        // sample was one edge ago.
        if (TOG == m_samp && TOG != m_level) begin
          m_level = TOG;
          chg_q.push_back(m_edge - 1 + LAT);
        end
      end
      m_samp = TOG;
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_x;
  always @(negedge CLK) begin
    if (RST === 1'b1 && EVT_PULSE === 1'b1) begin
      n_tests = n_tests + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL pulse_unexpected: pulse after edge %0d, none expected", m_edge);
      end else begin
        mon_x = sb.pop_front();
        if (mon_x.edge_n != m_edge || int'(EVT_CNT) != mon_x.cnt ||
            int'(PEND_CNT) != mon_x.pend || OVR !== mon_x.ovr) begin
          n_fail = n_fail + 1;
          $display("FAIL pulse_check: got edge=%0d cnt=%0d pend=%0d ovr=%0b required edge=%0d cnt=%0d pend=%0d ovr=%0b",
                   m_edge, EVT_CNT, PEND_CNT, OVR, mon_x.edge_n, mon_x.cnt, mon_x.pend, mon_x.ovr);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick(2);
    RST = 1'b1;
  endtask

  task automatic toggle_gap(input int gap);
    TOG = ~TOG;
    tick(gap);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pulse"}, EVT_PULSE, 0);
    check({tag, "_valid"}, EVT_VALID, 0);
    check({tag, "_pend"},  PEND_CNT,  0);
    check({tag, "_cnt"},   EVT_CNT,   0);
    check({tag, "_ovr"},   OVR,       0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int base_cnt;
  int gap;

  initial begin
    RST = 1'b0; TOG = 1'b1; EN = 1'b1; EVT_ACK = 1'b0; CLR_OVR = 1'b0;
    tick(3);
    check_outputs_zero("reset");

    // 1: TOG high through reset gives no event.
    RST = 1'b1;
    tick(10);
    check("s1_cnt", EVT_CNT, 0);
    check("s1_valid", EVT_VALID, 0);
    check("s1_sb_empty", sb.size(), 0);

    // 2: single event latency and acknowledge.
    TOG = 1'b0;
    do_reset();
    tick(PRIME_LEN + 3);
    TOG = 1'b1;
    for (int i = 0; i <= LAT + 1; i++) begin
      tick(1);
      check($sformatf("s2_pulse_at_%0d", i), EVT_PULSE, (i == LAT) ? 1 : 0);
    end
    check("s2_pend", PEND_CNT, 1);
    check("s2_valid", EVT_VALID, 1);
    check("s2_cnt", EVT_CNT, 1);
    EVT_ACK = 1'b1; tick(1); EVT_ACK = 1'b0;
    check("s2_pend_ack", PEND_CNT, 0);
    check("s2_valid_ack", EVT_VALID, 0);

    // 3: overrun after 17 unacknowledged events.
    do_reset();
    tick(PRIME_LEN + 3);
    for (int i = 0; i < 17; i++) toggle_gap(4);
    tick(6);
    check("s3_pend_sat", PEND_CNT, PEND_MAX);
    check("s3_ovr", OVR, 1);
    check("s3_cnt", EVT_CNT, 17);
    CLR_OVR = 1'b1; tick(1); CLR_OVR = 1'b0;
    check("s3_ovr_clr", OVR, 0);

    // 4: event and ack on the same edge leave PEND_CNT unchanged.
    do_reset();
    tick(PRIME_LEN + 3);
    for (int i = 0; i < 3; i++) toggle_gap(4);
    tick(4);
    check("s4_pend_pre", PEND_CNT, 3);
    TOG = ~TOG;
    tick(LAT);
    EVT_ACK = 1'b1; tick(1); EVT_ACK = 1'b0;
    check("s4_pulse", EVT_PULSE, 1);
    check("s4_pend", PEND_CNT, 3);
    check("s4_cnt", EVT_CNT, 4);

    // 5: disabled events are dropped, re-enable is silent.
    EN = 1'b0;
    for (int i = 0; i < 3; i++) toggle_gap(4);
    tick(4);
    EN = 1'b1;
    tick(10);
    check("s5_cnt", EVT_CNT, 4);
    check("s5_pend", PEND_CNT, 3);

    // 6: asynchronous reset mid-cycle with events pending.
    for (int i = 0; i < 2; i++) toggle_gap(4);
    tick(4);
    check("s6_pend_pre", PEND_CNT, 5);
    #2 RST = 1'b0;
    #1 check_outputs_zero("s6_async");
    @(negedge CLK);
    RST = 1'b1;
    tick(PRIME_LEN + 2);
    toggle_gap(8);
    check("s6_cnt_after", EVT_CNT, 1);
    check("s6_pend_after", PEND_CNT, 1);
`ifdef TOG_RX_GLITCH_FILT_EN
    TOG = ~TOG; tick(1); TOG = ~TOG;
    tick(8);
    check("s6_glitch_cnt", EVT_CNT, 1);
`endif

    // Randomised traffic against the model.
    gap = 4;
    for (int c = 0; c < 400; c++) begin
      EN      = ($urandom_range(0, 3) != 0);
      EVT_ACK = $urandom_range(0, 1);
      CLR_OVR = ($urandom_range(0, 15) == 0);
      if (gap >= 4 && $urandom_range(0, 2) == 0) begin
        TOG = ~TOG;
        gap = 0;
      end
      tick(1);
      gap = gap + 1;
      if (c % 40 == 39) begin
        check("rnd_pend", PEND_CNT, m_pend);
        check("rnd_cnt", EVT_CNT, m_cnt);
        check("rnd_ovr", OVR, m_ovr);
      end
    end
    EVT_ACK = 1'b0; CLR_OVR = 1'b0;
    tick(8);
    base_cnt = m_cnt;
    check("end_cnt", EVT_CNT, base_cnt);
    check("end_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
